// File: rtl/seq_muldiv_unit_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op codes, FSM states
// and the iteration-counter sizing helper.
package seq_muldiv_unit_pkg;

  typedef enum logic [1:0] {
    OP_MULTU = 2'b00,
    OP_DIVU  = 2'b01,
    OP_MULT  = 2'b10,
    OP_DIV   = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX,
    S_DONE
  } state_e;

  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/seq_muldiv_unit_if.sv
// Core-side handshake and operand/result bus of the multiply/divide unit.
interface seq_muldiv_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             dz;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (output start, op, a, b, input busy, done, dz, hi, lo);
  modport slave  (input start, op, a, b, output busy, done, dz, hi, lo);
endinterface

// File: rtl/seq_muldiv_ctrl.sv
// Sequencer for the multiply/divide unit: IDLE -> CALC (WIDTH cycles) -> FIX -> DONE,
// producing the load/step/fix strobes for the datapath and the busy/done handshake.
module seq_muldiv_ctrl
  import seq_muldiv_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic clk,
  input  logic reset_n,
  input  logic start,
  output logic busy,
  output logic done,
  output logic load,
  output logic step,
  output logic fix
);

  localparam int unsigned CW = cnt_width(WIDTH);

  state_e        state, state_nx;
  logic [CW-1:0] cnt;
  logic          last;

  assign last = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start) state_nx = S_CALC;
      S_CALC:  if (last)  state_nx = S_FIX;
      S_FIX:   state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state == S_CALC) || (state == S_FIX);
    done = (state == S_DONE);
    load = (state == S_IDLE) && start;
    step = (state == S_CALC);
    fix  = (state == S_FIX);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  cnt <= '0;
    else if (load) cnt <= '0;
    else if (step) cnt <= cnt + CW'(1);
  end

endmodule

// File: rtl/seq_muldiv_unit.sv
// Iterative one-bit-per-cycle multiply/divide unit (signed and unsigned) for the HI/LO
// path; works on magnitudes and restores signs in a single FIX cycle.
module seq_muldiv_unit
  import seq_muldiv_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  seq_muldiv_unit_if.slave  bus
);

  logic busy, done, load, step, fix;

  seq_muldiv_ctrl #(.WIDTH(WIDTH)) u_ctrl (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (bus.start),
    .busy    (busy),
    .done    (done),
    .load    (load),
    .step    (step),
    .fix     (fix)
  );

  op_e                op_in, op_q;
  logic               signed_in, div_in, sa, sb;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic               neg_q, neg_r;
  logic [WIDTH-1:0]   opnd_q;
  logic [2*WIDTH-1:0] acc, acc_step;
  logic [WIDTH:0]     add_sum, shifted;
  logic [WIDTH-1:0]   diff;
  logic               borrow;
  logic               div_q;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   res_hi, res_lo, hi_q, lo_q;
  logic               res_dz, dz_q;

  always_comb begin
    op_in     = op_e'(bus.op);
    signed_in = (op_in == OP_MULT) || (op_in == OP_DIV);
    div_in    = (op_in == OP_DIVU) || (op_in == OP_DIV);
    sa        = signed_in && bus.a[WIDTH-1];
    sb        = signed_in && bus.b[WIDTH-1];
    mag_a     = sa ? -bus.a : bus.a;
    mag_b     = sb ? -bus.b : bus.b;
  end

  // acc holds {partial product, multiplier} for mult and {remainder, dividend/quotient}
  // for div; the trial subtract is a W+1-bit compare plus a W-bit difference.
  always_comb begin
    div_q   = (op_q == OP_DIVU) || (op_q == OP_DIV);
    add_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd_q} : '0);
    shifted = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    borrow  = (shifted < {1'b0, opnd_q});
    diff    = shifted[WIDTH-1:0] - opnd_q;
    if (div_q) acc_step = {(borrow ? shifted[WIDTH-1:0] : diff), acc[WIDTH-2:0], ~borrow};
    else       acc_step = {add_sum, acc[WIDTH-1:1]};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_q   <= OP_MULTU;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      opnd_q <= '0;
      acc    <= '0;
    end else if (load) begin
      op_q  <= op_in;
      neg_q <= sa ^ sb;
      neg_r <= sa;
      if (div_in) begin
        acc    <= {{WIDTH{1'b0}}, mag_a};
        opnd_q <= mag_b;
      end else begin
        acc    <= {{WIDTH{1'b0}}, mag_b};
        opnd_q <= mag_a;
      end
    end else if (step) begin
      acc <= acc_step;
    end
  end

  // With a zero divisor every trial succeeds, so the remainder ends up as |a|;
  // re-applying the dividend sign returns a exactly as given.
  always_comb begin
    prod   = neg_q ? -acc : acc;
    res_dz = div_q && (opnd_q == '0);
    if (div_q) begin
      res_lo = res_dz ? '1 : (neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0]);
      res_hi = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    end else begin
      res_lo = prod[WIDTH-1:0];
      res_hi = prod[2*WIDTH-1:WIDTH];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hi_q <= '0;
      lo_q <= '0;
      dz_q <= 1'b0;
    end else if (fix) begin
      hi_q <= res_hi;
      lo_q <= res_lo;
      dz_q <= res_dz;
    end
  end

  assign bus.busy = busy;
  assign bus.done = done;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
  assign bus.dz   = dz_q;

endmodule

// File: tb/tb_seq_muldiv_unit.sv
// Self-checking bench for seq_muldiv_unit: directed literal cases plus randomized
// operations compared every cycle against an arithmetic reference model.
module tb_seq_muldiv_unit;

  localparam int W = 32;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  seq_muldiv_unit_if #(.WIDTH(32)) bus32 ();
  seq_muldiv_unit_if #(.WIDTH(8))  bus8 ();

  seq_muldiv_unit #(.WIDTH(32)) dut32 (.clk(clk), .reset_n(reset_n), .bus(bus32));
  seq_muldiv_unit #(.WIDTH(8))  dut8  (.clk(clk), .reset_n(reset_n), .bus(bus8));

  int checks = 0;
  int failures = 0;

  // model state: k = cycles since accepted start (0 = idle); held = {dz, hi, lo}
  int          k = 0;
  logic [64:0] pend = '0;
  logic [64:0] held = '0;

  function automatic logic [64:0] ref_model(input int w, input logic [1:0] op,
                                            input logic [31:0] a, input logic [31:0] b);
    logic [63:0] mask, ua, ub, p;
    longint      sa, sb, q, r;
    logic        dz;
    mask = (64'd1 << w) - 64'd1;
    ua   = {32'd0, a} & mask;
    ub   = {32'd0, b} & mask;
    sa   = ua[w-1] ? (longint'(ua) - longint'(64'd1 << w)) : longint'(ua);
    sb   = ub[w-1] ? (longint'(ub) - longint'(64'd1 << w)) : longint'(ub);
    dz   = 1'b0;
    p    = '0;
    case (op)
      2'b00: p = ua * ub;
      2'b10: p = 64'(sa * sb);
      default: begin
        if (ub == 0) begin
          dz = 1'b1;
          p  = (ua << w) | mask;
        end else if (op == 2'b01) begin
          p = ((ua % ub) << w) | (ua / ub);
        end else begin
          q = sa / sb;
          r = sa % sb;
          p = ((64'(r) & mask) << w) | (64'(q) & mask);
        end
      end
    endcase
    return {dz, 32'((p >> w) & mask), 32'(p & mask)};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      k    = 0;
      held = '0;
    end else if (k == 0) begin
      if (bus32.start === 1'b1) begin
        pend = ref_model(32, bus32.op, bus32.a, bus32.b);
        k    = 1;
      end
    end else if (k == W + 2) begin
      k = 0;
    end else begin
      k++;
      if (k == W + 2) held = pend;
    end
  end

  always @(negedge clk) begin
    chk("busy", 64'(bus32.busy), 64'(k >= 1 && k <= W + 1));
    chk("done", 64'(bus32.done), 64'(k == W + 2));
    chk("hi",   64'(bus32.hi),   64'(held[63:32]));
    chk("lo",   64'(bus32.lo),   64'(held[31:0]));
    chk("dz",   64'(bus32.dz),   64'(held[64]));
  end

  task automatic run32(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input int repulse, input bit start_in_done);
    int lat;
    @(posedge clk); #1;
    bus32.start = 1'b1; bus32.op = op; bus32.a = a; bus32.b = b;
    @(posedge clk); #1;
    bus32.start = 1'b0; bus32.op = 2'($urandom); bus32.a = $urandom; bus32.b = $urandom;
    lat = 1;
    while (bus32.done !== 1'b1 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
      bus32.start = (lat == repulse);
      if (lat == repulse) begin
        bus32.a = $urandom; bus32.b = $urandom; bus32.op = 2'($urandom);
      end
    end
    bus32.start = 1'b0;
    chk("latency32", 64'(lat), 64'(W + 2));
    if (start_in_done) begin
      bus32.start = 1'b1; bus32.op = 2'($urandom); bus32.a = $urandom; bus32.b = $urandom;
      @(posedge clk); #1;
      bus32.start = 1'b0;
    end
  endtask

  task automatic run8(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    int          lat;
    logic [64:0] e;
    e = ref_model(8, op, {24'd0, a}, {24'd0, b});
    @(posedge clk); #1;
    bus8.start = 1'b1; bus8.op = op; bus8.a = a; bus8.b = b;
    @(posedge clk); #1;
    bus8.start = 1'b0; bus8.a = 8'($urandom); bus8.b = 8'($urandom);
    lat = 1;
    while (bus8.done !== 1'b1 && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency8", 64'(lat), 64'd10);
    chk("w8_hi", 64'(bus8.hi), 64'(e[39:32]));
    chk("w8_lo", 64'(bus8.lo), 64'(e[7:0]));
    chk("w8_dz", 64'(bus8.dz), 64'(e[64]));
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'h0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h1;
      4:       return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    bus32.start = 1'b0; bus32.op = '0; bus32.a = '0; bus32.b = '0;
    bus8.start  = 1'b0; bus8.op  = '0; bus8.a  = '0; bus8.b  = '0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    chk("rst_busy", 64'(bus32.busy), 64'd0);
    chk("rst_hi",   64'(bus32.hi),   64'd0);
    chk("rst_lo",   64'(bus32.lo),   64'd0);

    run32(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0);
    chk("multu_hi", 64'(bus32.hi), 64'hFFFF_FFFE);
    chk("multu_lo", 64'(bus32.lo), 64'h0000_0001);
    chk("multu_dz", 64'(bus32.dz), 64'd0);
    run32(2'b01, 32'd100, 32'd7, 0, 1'b0);
    chk("divu_lo", 64'(bus32.lo), 64'd14);
    chk("divu_hi", 64'(bus32.hi), 64'd2);
    run32(2'b11, 32'hFFFF_FFF9, 32'd2, 0, 1'b0);
    chk("div_lo", 64'(bus32.lo), 64'hFFFF_FFFD);
    chk("div_hi", 64'(bus32.hi), 64'hFFFF_FFFF);
    run32(2'b10, 32'hFFFF_FFFD, 32'd5, 0, 1'b1);
    chk("mult_hi", 64'(bus32.hi), 64'hFFFF_FFFF);
    chk("mult_lo", 64'(bus32.lo), 64'hFFFF_FFF1);
    run32(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0);
    chk("minneg1_lo", 64'(bus32.lo), 64'h8000_0000);
    chk("minneg1_hi", 64'(bus32.hi), 64'd0);
    chk("minneg1_dz", 64'(bus32.dz), 64'd0);
    run32(2'b11, 32'hFFFF_FFFB, 32'd0, 0, 1'b0);
    chk("sdz_lo", 64'(bus32.lo), 64'hFFFF_FFFF);
    chk("sdz_hi", 64'(bus32.hi), 64'hFFFF_FFFB);
    chk("sdz_dz", 64'(bus32.dz), 64'd1);
    run32(2'b00, 32'd1000, 32'd3, 5, 1'b0);
    chk("repulse_lo", 64'(bus32.lo), 64'd3000);
    chk("repulse_hi", 64'(bus32.hi), 64'd0);
    run32(2'b10, 32'd0, 32'hDEAD_BEEF, 0, 1'b0);
    chk("mult0_lo", 64'(bus32.lo), 64'd0);
    run32(2'b01, 32'h1234, 32'd0, 0, 1'b0);
    chk("divz_lo", 64'(bus32.lo), 64'hFFFF_FFFF);
    chk("divz_hi", 64'(bus32.hi), 64'h1234);
    chk("divz_dz", 64'(bus32.dz), 64'd1);

    // abort an operation in CALC cycle 10 with reset
    @(posedge clk); #1;
    bus32.start = 1'b1; bus32.op = 2'b00; bus32.a = 32'd12345; bus32.b = 32'd678;
    @(posedge clk); #1;
    bus32.start = 1'b0;
    repeat (9) @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    chk("abort_busy", 64'(bus32.busy), 64'd0);
    chk("abort_done", 64'(bus32.done), 64'd0);
    chk("abort_hi",   64'(bus32.hi),   64'd0);
    chk("abort_lo",   64'(bus32.lo),   64'd0);
    chk("abort_dz",   64'(bus32.dz),   64'd0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    run32(2'b01, 32'd9, 32'd3, 0, 1'b0);
    chk("post_rst_lo", 64'(bus32.lo), 64'd3);
    chk("post_rst_hi", 64'(bus32.hi), 64'd0);

    for (int i = 0; i < 60; i++) begin
      run32(2'($urandom_range(0, 3)), pick(), pick(),
            ($urandom_range(0, 3) == 0) ? int'($urandom_range(2, W + 1)) : 0,
            ($urandom_range(0, 3) == 0));
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    run8(2'b11, 8'h80, 8'h03);
    chk("w8_min_lo", 64'(bus8.lo), 64'hD6);
    chk("w8_min_hi", 64'(bus8.hi), 64'hFE);
    for (int i = 0; i < 30; i++) begin
      run8(2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom_range(0, 4) == 0 ? 0 : $urandom));
    end

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
